// File: rtl/uart_pkg.sv
// Shared UART definitions for the RX controller, the baud tick generator and
// the TX controller.
//   rx_state_t       : receive frame sequencer states
//   DEF_SAMPLE_RATE  : default oversample ticks per bit period
//   DEF_DATA_BITS    : default data bits per frame
//   DEF_DIVISOR      : default clocks per oversample tick
package uart_pkg;

  localparam int unsigned DEF_SAMPLE_RATE = 16;
  localparam int unsigned DEF_DATA_BITS   = 8;
  localparam int unsigned DEF_DIVISOR     = 4;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
//   clock : system clock
//   reset : synchronous, active-high; both stages load RESET_VALUE
//   d     : asynchronous input
//   q     : synchronized output (two clocks of latency)
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_controller.sv
// Receive-side UART frame controller (8N1 by default).
// Detects the start-bit edge, re-phases the shared baud tick generator with
// start_rx, samples start/data/stop bits at mid-bit by counting oversample
// ticks and hands complete frames to the consumer through a one-entry
// valid/ready output register.
//   clock         : system clock
//   reset         : synchronous, active-high
//   rx_in         : asynchronous serial line, idles high
//   tick          : 1-cycle oversample tick from the baud generator
//   start_rx      : 1-cycle pulse, half-period preload of the baud generator
//   rx_data       : last accepted frame, stable while rx_valid is high
//   rx_valid      : rx_data holds an unconsumed frame
//   rx_ready      : consumer accepts; transfer on rx_valid & rx_ready
//   framing_error : 1-cycle pulse, stop bit sampled low
//   overrun       : 1-cycle pulse, frame completed with the buffer full (dropped)
module uart_rx_controller
  import uart_pkg::*;
#(
  parameter int unsigned SAMPLE_RATE = DEF_SAMPLE_RATE,
  parameter int unsigned DATA_BITS   = DEF_DATA_BITS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx_in,
  input  logic                 tick,
  output logic                 start_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 framing_error,
  output logic                 overrun
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_RATE);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(SAMPLE_RATE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_RATE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic rx_s;

  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 framing_error_q, framing_error_d;
  logic                 overrun_q, overrun_d;
  logic                 rx_d_q, rx_d_d;
  logic                 deliver;

  sync_2ff #(
    .RESET_VALUE(1'b1)
  ) u_rx_sync (
    .clock(clock),
    .reset(reset),
    .d    (rx_in),
    .q    (rx_s)
  );

  // Falling edge of the synchronized line while idle.
  assign start_rx = (state_q == RX_IDLE) & rx_d_q & ~rx_s;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    idx_d           = idx_q;
    shift_d         = shift_q;
    rx_data_d       = rx_data_q;
    framing_error_d = 1'b0;
    overrun_d       = 1'b0;
    rx_d_d          = rx_s;
    deliver         = 1'b0;

    // Consumer handshake drains the buffer; a delivery below may refill it.
    rx_valid_d = rx_valid_q & ~rx_ready;

    case (state_q)
      RX_IDLE: begin
        if (start_rx) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end

      RX_START: begin
        if (tick) begin
          if (cnt_q == CNT_HALF) begin
            if (!rx_s) begin
              state_d = RX_DATA;
              cnt_d   = '0;
              idx_d   = '0;
            end else begin
              state_d = RX_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      RX_DATA: begin
        if (tick) begin
          if (cnt_q == CNT_LAST) begin
            shift_d[idx_q] = rx_s;
            cnt_d          = '0;
            if (idx_q == IDX_LAST) begin
              state_d = RX_STOP;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      RX_STOP: begin
        if (tick) begin
          if (cnt_q == CNT_LAST) begin
            if (rx_s) begin
              deliver = 1'b1;
              state_d = RX_IDLE;
            end else begin
              framing_error_d = 1'b1;
              state_d         = RX_BREAK;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      // Hold here while the line stays low so a break is not seen as a new start.
      RX_BREAK: begin
        if (rx_s) begin
          state_d = RX_IDLE;
        end
      end

      default: begin
        state_d = RX_IDLE;
      end
    endcase

    if (deliver) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= RX_IDLE;
      cnt_q           <= '0;
      idx_q           <= '0;
      shift_q         <= '0;
      rx_data_q       <= '0;
      rx_valid_q      <= 1'b0;
      framing_error_q <= 1'b0;
      overrun_q       <= 1'b0;
      rx_d_q          <= 1'b1;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      idx_q           <= idx_d;
      shift_q         <= shift_d;
      rx_data_q       <= rx_data_d;
      rx_valid_q      <= rx_valid_d;
      framing_error_q <= framing_error_d;
      overrun_q       <= overrun_d;
      rx_d_q          <= rx_d_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign framing_error = framing_error_q;
  assign overrun       = overrun_q;

endmodule
